// File: rtl/instruction_fetch_stage_pkg.sv
// Shared constants, types and helpers for the instruction fetch stage.
// Build option: define IF_STALL_COUNTER_EN to add the freezeCycles counter output.
package instruction_fetch_stage_pkg;

   localparam int          ADDR_WIDTH_DEF = 32;
   localparam int          DATA_WIDTH_DEF = 32;
   localparam int          BUF_DEPTH_DEF  = 2;
   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
   localparam int          WORD_BYTES     = 4;

   // What happens to a read response in the current cycle.
   typedef enum logic [1:0] {
      RESP_NONE,
      RESP_DROP,
      RESP_PUSH
   } resp_e;

   // Width of a counter that must hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory read port: request/grant for addresses, in-order valid-qualified read data.
interface instruction_fetch_stage_if
   import instruction_fetch_stage_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

   logic                  memReq;
   logic [ADDR_WIDTH-1:0] memAddr;
   logic                  memGnt;
   logic                  memRdValid;
   logic [DATA_WIDTH-1:0] memRdData;

   modport master (
      output memReq,
      output memAddr,
      input  memGnt,
      input  memRdValid,
      input  memRdData
   );

   modport slave (
      input  memReq,
      input  memAddr,
      output memGnt,
      output memRdValid,
      output memRdData
   );

endinterface

// File: rtl/instruction_fetch_stage_fetch_buffer.sv
// Circular prefetch FIFO with push, pop, synchronous flush, occupancy count and head data.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module fetch_buffer
   import instruction_fetch_stage_pkg::*;
#(
   parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int  DEPTH      = BUF_DEPTH_DEF,
   localparam int PTR_W      = $clog2(DEPTH),
   localparam int CNT_W      = cnt_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_flush,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_pop,
   output logic [CNT_W-1:0]      o_count,
   output logic                  o_empty,
   output logic [DATA_WIDTH-1:0] o_head
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [CNT_W-1:0]      r_count;
   logic                  w_do_pop;
   logic                  w_do_push;

   assign o_empty   = (r_count == '0);
   assign w_do_pop  = i_pop && !o_empty;
   // A full buffer still accepts a push when the head leaves in the same cycle.
   assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

   // NOTE: non-blocking assignments so every register here samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
      end
   end

   // NOTE: the storage array has no reset; r_count alone says which slots hold valid words.
   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Pipeline IF stage: owns the fetch PC, issues in-order reads, buffers words for IF/ID.
// Build option: define IF_STALL_COUNTER_EN to add the saturating freezeCycles output.
module instruction_fetch_stage
   import instruction_fetch_stage_pkg::*;
#(
   parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int                    BUF_DEPTH  = BUF_DEPTH_DEF,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      freeze,
   input  logic                      branchTaken,
   input  logic [ADDR_WIDTH-1:0]     branchAddress,
   instruction_fetch_stage_if.master mem,
   output logic                      instValid,
   output logic [DATA_WIDTH-1:0]     instruction,
   output logic [ADDR_WIDTH-1:0]     pcPlus4
`ifdef IF_STALL_COUNTER_EN
   ,
   output logic [31:0]               freezeCycles
`endif
);

   localparam int                    CNT_W       = cnt_width(BUF_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(WORD_BYTES);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ~ADDR_WIDTH'(WORD_BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;
   localparam logic [CNT_W:0]        DEPTH_C     = (CNT_W + 1)'(BUF_DEPTH);

   logic [ADDR_WIDTH-1:0] r_fetch_pc;
   logic [ADDR_WIDTH-1:0] r_deliver_pc;
   logic [CNT_W-1:0]      r_outstanding;
   logic [CNT_W-1:0]      r_discard;

   logic [CNT_W-1:0]      w_count;
   logic                  w_empty;
   logic [DATA_WIDTH-1:0] w_head;
   logic [CNT_W:0]        w_used;
   logic                  w_pop;
   logic                  w_req;
   logic                  w_grant;
   logic                  w_resp_taken;
   logic [ADDR_WIDTH-1:0] w_target;
   resp_e                 w_resp;

   assign w_target = branchAddress & ALIGN_MASK;
   assign w_pop    = !w_empty && !freeze && !branchTaken;

   // Outstanding reads (squashed ones included) plus buffered words must fit the
   // buffer; a same-cycle pop frees one slot so a 1-cycle memory streams at full rate.
   assign w_used  = {1'b0, r_outstanding} + {1'b0, w_count};
   assign w_req   = rst && !branchTaken && (w_used < DEPTH_C + {{CNT_W{1'b0}}, w_pop});
   assign w_grant = w_req && mem.memGnt;

   assign mem.memReq  = w_req;
   assign mem.memAddr = r_fetch_pc;

   // Responses with nothing outstanding are strays from before a reset and are ignored.
   always_comb begin
      // NOTE: defaults first so every path assigns w_resp and no latch is inferred.
      w_resp = RESP_NONE;
      if (mem.memRdValid && (r_outstanding != '0)) begin
         if (branchTaken || (r_discard != '0)) w_resp = RESP_DROP;
         else                                  w_resp = RESP_PUSH;
      end
   end

   assign w_resp_taken = (w_resp != RESP_NONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_pc    <= RESET_PC_AL;
         r_deliver_pc  <= RESET_PC_AL;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else if (branchTaken) begin
         // No grant can happen here, so every read still in flight becomes a discard.
         r_fetch_pc    <= w_target;
         r_deliver_pc  <= w_target;
         r_outstanding <= r_outstanding - CNT_W'(w_resp_taken);
         r_discard     <= r_outstanding - CNT_W'(w_resp_taken);
      end else begin
         if (w_grant) r_fetch_pc   <= r_fetch_pc + PC_STEP;
         if (w_pop)   r_deliver_pc <= r_deliver_pc + PC_STEP;
         r_outstanding <= r_outstanding + CNT_W'(w_grant) - CNT_W'(w_resp_taken);
         if (w_resp == RESP_DROP) r_discard <= r_discard - CNT_W'(1);
      end
   end

   fetch_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BUF_DEPTH)
   ) u_fetch_buffer (
      .clk     (clk),
      .rst     (rst),
      .i_flush (branchTaken),
      .i_push  (w_resp == RESP_PUSH),
      .i_data  (mem.memRdData),
      .i_pop   (w_pop),
      .o_count (w_count),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   assign instValid   = !w_empty;
   assign instruction = w_empty ? '0 : w_head;
   assign pcPlus4     = r_deliver_pc + PC_STEP;

`ifdef IF_STALL_COUNTER_EN
   logic [31:0] r_freeze_cycles;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_freeze_cycles <= '0;
      end else if (freeze && instValid && !branchTaken && (r_freeze_cycles != '1)) begin
         r_freeze_cycles <= r_freeze_cycles + 32'd1;
      end
   end

   assign freezeCycles = r_freeze_cycles;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Randomized bench for instruction_fetch_stage: an in-order memory model drives the read
// port and a queue-based reference model of the stage predicts every output each cycle.
module tb_instruction_fetch_stage;
   import instruction_fetch_stage_pkg::*;

   localparam int          AW     = 32;
   localparam int          DW     = 32;
   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0002;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          freeze = 1'b0;
   logic          branchTaken = 1'b0;
   logic [AW-1:0] branchAddress = '0;
   logic          instValid;
   logic [DW-1:0] instruction;
   logic [AW-1:0] pcPlus4;
`ifdef IF_STALL_COUNTER_EN
   logic [31:0]   freezeCycles;
`endif

   instruction_fetch_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();

   instruction_fetch_stage #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .BUF_DEPTH  (DEPTH),
      .RESET_PC   (RST_PC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .freeze        (freeze),
      .branchTaken   (branchTaken),
      .branchAddress (branchAddress),
      .mem           (mif),
      .instValid     (instValid),
      .instruction   (instruction),
      .pcPlus4       (pcPlus4)
`ifdef IF_STALL_COUNTER_EN
      ,
      .freezeCycles  (freezeCycles)
`endif
   );

   always #5 clk = ~clk;

   // Scoreboard counters and checker.
   int n_compared   = 0;
   int n_mismatched = 0;
   int cyc          = 0;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, observed, expected, cyc);
      end
   endtask

   // Reference model: words in flight (1 = squashed by a branch) and buffered words.
   logic [AW-1:0] m_fetch_pc;
   logic [AW-1:0] m_deliver_pc;
   bit            m_inflight[$];
   logic [DW-1:0] m_buf[$];
   logic [31:0]   m_frz_cnt;

   // Memory model: granted reads returned in order after a random latency.
   typedef struct {
      logic [AW-1:0] addr;
      int            due;
      bit            stray;
   } mem_req_t;
   mem_req_t mem_q[$];

   int            knob_gnt_pct;
   int            knob_frz_pct;
   int            knob_br_pct;
   int            knob_lat_min;
   int            knob_lat_max;
   bit            force_branch = 1'b0;
   logic [AW-1:0] force_addr   = '0;

   task automatic set_knobs(input int gnt, input int frz, input int br, input int lmin, input int lmax);
      knob_gnt_pct = gnt;
      knob_frz_pct = frz;
      knob_br_pct  = br;
      knob_lat_min = lmin;
      knob_lat_max = lmax;
   endtask

   task automatic model_reset();
      m_fetch_pc   = RST_PC & ~32'h3;
      m_deliver_pc = RST_PC & ~32'h3;
      m_inflight.delete();
      m_buf.delete();
      m_frz_cnt = '0;
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
   task automatic apply_reset();
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("rst_memReq", 32'(mif.memReq), 32'd0);
      check("rst_instValid", 32'(instValid), 32'd0);
      check("rst_instruction", instruction, 32'd0);
      check("rst_pcPlus4", pcPlus4, (RST_PC & ~32'h3) + 32'd4);
`ifdef IF_STALL_COUNTER_EN
      check("rst_freezeCycles", freezeCycles, 32'd0);
`endif
      freeze          = 1'b0;
      branchTaken     = 1'b0;
      mif.memGnt      = 1'b0;
      mif.memRdValid  = 1'b0;
      foreach (mem_q[i]) mem_q[i].stray = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run_cycle();
      bit  exp_req;
      bit  exp_pop;
      bit  had_inst;
      bit  grant;
      bit  stale;
      bit  block;
      int  due;

      @(negedge clk);
      freeze      = ($urandom_range(0, 99) < knob_frz_pct);
      branchTaken = force_branch || ($urandom_range(0, 99) < knob_br_pct);
      if (force_branch)                     branchAddress = force_addr;
      else if ($urandom_range(0, 7) == 0)   branchAddress = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                                  branchAddress = $urandom;
      force_branch = 1'b0;

      // Hold off new grants until stray pre-reset responses have drained.
      block          = (mem_q.size() > 0) && mem_q[0].stray;
      mif.memGnt     = !block && ($urandom_range(0, 99) < knob_gnt_pct);
      mif.memRdValid = 1'b0;
      mif.memRdData  = $urandom;
      if ((mem_q.size() > 0) && (mem_q[0].due <= cyc)) begin
         mif.memRdValid = 1'b1;
         mif.memRdData  = mem_q[0].addr;
         void'(mem_q.pop_front());
      end

      #1;
      had_inst = (m_buf.size() > 0);
      exp_pop  = had_inst && !freeze && !branchTaken;
      exp_req  = !branchTaken && ((m_inflight.size() + m_buf.size()) < (DEPTH + int'(exp_pop)));

      check("memReq", 32'(mif.memReq), 32'(exp_req));
      if (exp_req) check("memAddr", mif.memAddr, m_fetch_pc);
      check("instValid", 32'(instValid), 32'(had_inst));
      check("instruction", instruction, had_inst ? m_buf[0] : 32'd0);
      check("pcPlus4", pcPlus4, m_deliver_pc + 32'd4);
`ifdef IF_STALL_COUNTER_EN
      check("freezeCycles", freezeCycles, m_frz_cnt);
`endif

      // Memory side follows what the DUT actually requested.
      if (mif.memReq && mif.memGnt) begin
         due = cyc + $urandom_range(knob_lat_min, knob_lat_max);
         if ((mem_q.size() > 0) && (mem_q[$].due >= due)) due = mem_q[$].due + 1;
         mem_q.push_back('{addr: mif.memAddr, due: due, stray: 1'b0});
      end

      // Advance the reference model across the coming rising edge.
      grant = exp_req && mif.memGnt;
      if (mif.memRdValid && (m_inflight.size() > 0)) begin
         stale = m_inflight.pop_front();
         if (!stale && !branchTaken) m_buf.push_back(mif.memRdData);
      end
      if (freeze && had_inst && !branchTaken && (m_frz_cnt != 32'hFFFF_FFFF)) m_frz_cnt++;
      if (branchTaken) begin
         m_buf.delete();
         foreach (m_inflight[i]) m_inflight[i] = 1'b1;
         m_fetch_pc   = branchAddress & ~32'h3;
         m_deliver_pc = branchAddress & ~32'h3;
      end else begin
         if (exp_pop) begin
            void'(m_buf.pop_front());
            m_deliver_pc = m_deliver_pc + 32'd4;
         end
         if (grant) begin
            m_inflight.push_back(1'b0);
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
      end
      cyc++;
   endtask

   initial begin
      mif.memGnt     = 1'b0;
      mif.memRdValid = 1'b0;
      mif.memRdData  = '0;
      set_knobs(100, 0, 0, 1, 1);
      apply_reset();

      // Single-cycle memory, always granting: one instruction per cycle.
      repeat (12) run_cycle();

      // Freeze held three cycles, then released.
      set_knobs(100, 100, 0, 1, 1);
      repeat (3) run_cycle();
      set_knobs(100, 0, 0, 1, 1);
      repeat (6) run_cycle();

      // Grant withheld five cycles: request and address must hold.
      set_knobs(0, 0, 0, 1, 1);
      repeat (5) run_cycle();
      set_knobs(100, 0, 0, 1, 1);
      repeat (6) run_cycle();

      // Slow memory, misaligned redirect with reads in flight.
      set_knobs(100, 0, 0, 3, 3);
      repeat (3) run_cycle();
      force_branch = 1'b1;
      force_addr   = 32'h0000_0103;
      repeat (12) run_cycle();

      // Redirect while frozen with a response landing in the same cycle.
      set_knobs(100, 100, 0, 2, 2);
      repeat (2) run_cycle();
      force_branch = 1'b1;
      force_addr   = 32'h0000_0200;
      repeat (6) run_cycle();

      // Fetch PC wrapping past the top of the address space.
      set_knobs(100, 0, 0, 1, 2);
      force_branch = 1'b1;
      force_addr   = 32'hFFFF_FFF6;
      repeat (10) run_cycle();

      // Reset in the middle of a stream with reads outstanding.
      set_knobs(100, 0, 0, 3, 3);
      repeat (3) run_cycle();
      apply_reset();
      set_knobs(100, 0, 0, 1, 1);
      repeat (10) run_cycle();

      // Random soak with periodically changing traffic shape.
      for (int i = 0; i < 3000; i++) begin
         if ((i % 100) == 0)
            set_knobs($urandom_range(20, 100), $urandom_range(0, 60), $urandom_range(0, 15), 1,
                      $urandom_range(1, 4));
         if ((i % 997) == 500) apply_reset();
         run_cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
